// File: rtl/lotr_ring_fabric.sv
// Unidirectional NUM_STOPS ring: per stop one slot register, injection FIFO, registered ejection.
// Latency: push at t -> slot at t+2 -> EjValid at t+2+hops; ring never stalls, injection waits for a free slot.

module lotr_ring_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
endmodule

module lotr_ring_fabric #(
    parameter int                   NUM_STOPS   = 4,
    parameter int                   PKT_W       = 106,
    parameter int                   DEST_LSB    = 56,
    parameter int                   INJ_DEPTH   = 4,
    parameter int                   STARVE_MAX  = 8,
    parameter logic [NUM_STOPS-1:0] BYPASS_MASK = '0
) (
    input  logic                       QClk,
    input  logic                       RstQnnnL,
    input  logic [NUM_STOPS-1:0]       InjValid,
    input  logic [NUM_STOPS*PKT_W-1:0] InjPkt,
    output logic [NUM_STOPS-1:0]       InjReady,
    output logic [NUM_STOPS-1:0]       EjValid,
    output logic [NUM_STOPS*PKT_W-1:0] EjPkt,
    output logic [NUM_STOPS-1:0]       StarveFlag,
    output logic                       DropPulse,
    output logic [15:0]                DropCnt
);
    localparam int SCW = $clog2(STARVE_MAX + 1);

    logic [NUM_STOPS-1:0] slot_vld;
    logic [PKT_W-1:0]     slot_pkt  [NUM_STOPS];
    logic [4:0]           slot_hops [NUM_STOPS];
    logic [NUM_STOPS-1:0] drop_vec;
    logic [NUM_STOPS-1:0] starve_first;
    logic [NUM_STOPS-1:0] throttled;
    logic [4:0]           drop_num;
    logic [16:0]          drop_sum;

    // Only the lowest-index starving stop keeps its injection right.
    assign starve_first = StarveFlag & (~StarveFlag + {{(NUM_STOPS-1){1'b0}}, 1'b1});
    assign throttled    = (|StarveFlag) ? ~starve_first : '0;

    for (genvar i = 0; i < NUM_STOPS; i++) begin : g_stop
        localparam int         PREV    = (i == 0) ? NUM_STOPS - 1 : i - 1;
        localparam logic [7:0] STOP_ID = 8'(i + 1);
        localparam logic       BYP     = BYPASS_MASK[i];

        logic             in_vld;
        logic [PKT_W-1:0] in_pkt;
        logic [4:0]       in_hops;
        logic             do_eject;
        logic             do_drop;
        logic             do_fwd;
        logic             do_inj;
        logic             blocked;
        logic             fifo_empty;
        logic             fifo_full;
        logic [PKT_W-1:0] head;
        logic             vld_q;
        logic [PKT_W-1:0] pkt_q;
        logic [4:0]       hops_q;
        logic             ej_vld_q;
        logic [PKT_W-1:0] ej_pkt_q;
        logic [SCW-1:0]   starve_cnt;

        assign in_vld  = slot_vld[PREV];
        assign in_pkt  = slot_pkt[PREV];
        assign in_hops = slot_hops[PREV];

        assign do_eject = in_vld && (in_pkt[DEST_LSB +: 8] == STOP_ID) && !BYP;
        assign do_drop  = in_vld && !do_eject && (in_hops == 5'(NUM_STOPS));
        assign do_fwd   = in_vld && !do_eject && !do_drop;
        assign do_inj   = !do_fwd && !fifo_empty && !BYP && !throttled[i];
        assign blocked  = do_fwd && !fifo_empty && !BYP;

        lotr_ring_fifo #(.W(PKT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
            .clk      (QClk),
            .rst_n    (RstQnnnL),
            .push     (InjValid[i] && InjReady[i]),
            .push_dat (InjPkt[i*PKT_W +: PKT_W]),
            .pop      (do_inj),
            .head_dat (head),
            .empty    (fifo_empty),
            .full     (fifo_full)
        );

        always_ff @(posedge QClk or negedge RstQnnnL) begin
            if (!RstQnnnL) begin
                vld_q      <= 1'b0;
                pkt_q      <= '0;
                hops_q     <= '0;
                ej_vld_q   <= 1'b0;
                ej_pkt_q   <= '0;
                starve_cnt <= '0;
            end else begin
                vld_q    <= do_fwd || do_inj;
                ej_vld_q <= do_eject;
                if (do_eject) ej_pkt_q <= in_pkt;
                if (do_fwd) begin
                    pkt_q  <= in_pkt;
                    hops_q <= in_hops + 5'd1;
                end else if (do_inj) begin
                    pkt_q  <= head;
                    hops_q <= 5'd1;
                end
                if (do_inj)
                    starve_cnt <= '0;
                else if (blocked && (starve_cnt < SCW'(STARVE_MAX)))
                    starve_cnt <= starve_cnt + SCW'(1);
            end
        end

        assign slot_vld[i]              = vld_q;
        assign slot_pkt[i]              = pkt_q;
        assign slot_hops[i]             = hops_q;
        assign drop_vec[i]              = do_drop;
        assign InjReady[i]              = !fifo_full && !BYP;
        assign EjValid[i]               = ej_vld_q;
        assign EjPkt[i*PKT_W +: PKT_W]  = ej_pkt_q;
        assign StarveFlag[i]            = (starve_cnt >= SCW'(STARVE_MAX));
    end

    // Several stops can drop in the same cycle; each counts once.
    always_comb begin
        drop_num = '0;
        for (int k = 0; k < NUM_STOPS; k++)
            drop_num = drop_num + {4'd0, drop_vec[k]};
    end

    assign drop_sum = {1'b0, DropCnt} + {12'd0, drop_num};

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            DropPulse <= 1'b0;
            DropCnt   <= '0;
        end else begin
            DropPulse <= |drop_vec;
            DropCnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule
